// File: rtl/pipe3_flow_ctrl_if.sv
// Ready/valid stream bundle for pipe3_flow_ctrl: producer side (d/in_valid/in_ready)
// and consumer side (q3/out_valid/out_ready). The DUT takes the slave view.
interface pipe3_flow_ctrl_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] q3;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output d, in_valid, out_ready,
        input  in_ready, q3, out_valid
    );

    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, q3, out_valid
    );
endinterface

// File: rtl/pipe3_flow_ctrl.sv
// Three-stage ready/valid pipeline register with bubble collapse, synchronous flush,
// occupancy status and a wrapping output-transfer counter.
module pipe3_flow_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe3_flow_ctrl_if.slave   bus,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   xfer_cnt
);

    logic [WIDTH-1:0] s1, s2, s3;
    logic             v1, v2, v3;
    logic             en1, en2, en3;
    logic             nv1, nv2, nv3;
    logic             xfer_go;

    // A stage may advance when it is empty or the stage ahead is draining.
    assign en3 = !v3 | bus.out_ready;
    assign en2 = !v2 | en3;
    assign en1 = !v1 | en2;

    assign bus.in_ready  = en1 & !flush;
    assign bus.q3        = s3;
    assign bus.out_valid = v3;

    assign xfer_go = v3 & bus.out_ready & !flush;

    always_comb begin
        nv1 = v1;
        nv2 = v2;
        nv3 = v3;
        if (flush) begin
            nv1 = 1'b0;
            nv2 = 1'b0;
            nv3 = 1'b0;
        end else begin
            if (en3) nv3 = v2;
            if (en2) nv2 = v1;
            if (en1) nv1 = bus.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            occupancy <= 2'd0;
            xfer_cnt  <= '0;
        end else begin
            v1        <= nv1;
            v2        <= nv2;
            v3        <= nv3;
            occupancy <= {1'b0, nv1} + {1'b0, nv2} + {1'b0, nv3};
            // Data only moves behind a valid item; flush leaves the data registers alone.
            if (!flush) begin
                if (en1 && bus.in_valid) s1 <= bus.d;
                if (en2 && v1)           s2 <= s1;
                if (en3 && v2)           s3 <= s2;
            end
            if (xfer_go) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe3_flow_ctrl.sv
// Self-checking bench for pipe3_flow_ctrl: queue-of-items reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pipe3_flow_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] occupancy;
    logic [15:0] xfer_cnt;

    logic       w_rst_n;
    logic       w_flush;
    logic [1:0] w_occ;
    logic [3:0] w_cnt;

    pipe3_flow_ctrl_if #(.WIDTH(8)) bus ();
    pipe3_flow_ctrl_if #(.WIDTH(8)) w_bus ();

    pipe3_flow_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    pipe3_flow_ctrl #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .bus       (w_bus),
        .flush     (w_flush),
        .occupancy (w_occ),
        .xfer_cnt  (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    bit chk_en;

    // Reference model: in-flight items oldest first, each with its stage position 1..3.
    logic [7:0] mq_data[$];
    int         mq_pos[$];
    int         m_cnt;
    logic [7:0] m_q3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each item steps one stage forward unless blocked by the item ahead; the oldest
    // item leaves from stage 3 when the consumer is ready. lim = highest free stage left.
    function automatic void plan(input bit ordy, output bit [2:0][2:0] np,
                                 output bit lv, output int lim);
        int nxt;
        lim = 3;
        lv  = 1'b0;
        np  = '0;
        for (int i = 0; i < mq_pos.size(); i++) begin
            if (i == 0 && mq_pos[0] == 3 && ordy) begin
                lv = 1'b1;
            end else begin
                nxt   = (mq_pos[i] + 1 < lim) ? mq_pos[i] + 1 : lim;
                np[i] = 3'(nxt);
                lim   = nxt - 1;
            end
        end
    endfunction

    task automatic model_reset();
        mq_data.delete();
        mq_pos.delete();
        m_cnt = 0;
        m_q3  = 8'h00;
    endtask

    task automatic model_update();
        bit [2:0][2:0] np;
        bit            lv;
        int            lim;
        if (!rst_n) return;
        if (flush) begin
            mq_data.delete();
            mq_pos.delete();
            return;
        end
        plan(bus.out_ready, np, lv, lim);
        for (int i = 0; i < mq_pos.size(); i++) mq_pos[i] = int'(np[i]);
        if (lv) begin
            void'(mq_pos.pop_front());
            void'(mq_data.pop_front());
            m_cnt++;
        end
        if (bus.in_valid && lim >= 1) begin
            mq_data.push_back(bus.d);
            mq_pos.push_back(1);
        end
        foreach (mq_pos[i]) if (mq_pos[i] == 3) m_q3 = mq_data[i];
    endtask

    task automatic compare_model();
        bit [2:0][2:0] np;
        bit            lv;
        int            lim;
        bit            ov;
        plan(bus.out_ready, np, lv, lim);
        ov = (mq_pos.size() > 0) && (mq_pos[0] == 3);
        chk("m_in_ready",  32'(bus.in_ready),  32'(!flush && lim >= 1));
        chk("m_out_valid", 32'(bus.out_valid), 32'(ov));
        chk("m_q3",        32'(bus.q3),        32'(m_q3));
        chk("m_occupancy", 32'(occupancy),     32'(mq_pos.size()));
        chk("m_xfer_cnt",  32'(xfer_cnt),      32'(m_cnt & 16'hFFFF));
    endtask

    // One clock: compare at the falling edge, step the model at the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (chk_en) compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit iv, input logic [7:0] dv, input bit ordy);
        bus.in_valid  = iv;
        bus.d         = dv;
        bus.out_ready = ordy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        chk_en  = 1'b1;
        flush   = 1'b0;
        w_flush = 1'b0;
        w_rst_n = 1'b0;
        w_bus.in_valid  = 1'b0;
        w_bus.d         = 8'h00;
        w_bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy),     32'd0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),      32'd0);
        chk("rst_q3",        32'(bus.q3),        32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Streaming 0x01..0x0A with the consumer always ready.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            #1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            cyc();
            chk("stream_out_valid", 32'(bus.out_valid), 32'(i >= 3));
            if (i >= 3) chk("stream_q3", 32'(bus.q3), 32'(i - 2));
            chk("stream_xfer", 32'(xfer_cnt), 32'(i > 3 ? i - 3 : 0));
        end
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        cyc();
        chk("stream_last_q3", 32'(bus.q3), 32'h0A);
        cyc();
        chk("stream_xfer_total", 32'(xfer_cnt), 32'd10);
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure fill then a single-cycle consumer ready.
        drive(1'b1, 8'h11, 1'b0); cyc();
        drive(1'b1, 8'h22, 1'b0); cyc();
        drive(1'b1, 8'h33, 1'b0); cyc();
        drive(1'b1, 8'h44, 1'b0);
        #1;
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_occ_full",      32'(occupancy),    32'd3);
        chk("bp_q3_full",       32'(bus.q3),       32'h11);
        cyc();
        chk("bp_hold_q3",  32'(bus.q3),    32'h11);
        chk("bp_hold_occ", 32'(occupancy), 32'd3);
        drive(1'b1, 8'h44, 1'b1);
        #1;
        chk("bp_in_ready_pass", 32'(bus.in_ready), 32'd1);
        cyc();
        chk("bp_occ_pass",  32'(occupancy), 32'd3);
        chk("bp_q3_pass",   32'(bus.q3),    32'h22);
        chk("bp_xfer_pass", 32'(xfer_cnt),  32'd11);
        drive(1'b0, 8'h00, 1'b1);
        cyc(); cyc();
        chk("bp_q3_last", 32'(bus.q3), 32'h44);
        cyc();
        chk("bp_xfer_total", 32'(xfer_cnt), 32'd14);

        // Bubble collapse with a stalled consumer.
        drive(1'b1, 8'hA5, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0); cyc(); cyc();
        drive(1'b1, 8'h5A, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0); cyc();
        chk("bub_q3",  32'(bus.q3),    32'hA5);
        chk("bub_occ", 32'(occupancy), 32'd2);
        drive(1'b0, 8'h00, 1'b1); cyc();
        chk("bub_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bub_next_q3",    32'(bus.q3),        32'h5A);
        cyc();
        chk("bub_empty", 32'(bus.out_valid), 32'd0);
        chk("bub_xfer",  32'(xfer_cnt),      32'd16);

        // Flush with a full pipe and everybody ready.
        drive(1'b1, 8'h61, 1'b0); cyc();
        drive(1'b1, 8'h62, 1'b0); cyc();
        drive(1'b1, 8'h63, 1'b0); cyc();
        drive(1'b1, 8'h64, 1'b1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_occ",       32'(occupancy),     32'd0);
        chk("fl_xfer",      32'(xfer_cnt),      32'd16);
        drive(1'b1, 8'h70, 1'b1); cyc();
        drive(1'b0, 8'h00, 1'b1);
        chk("fl_lat1", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("fl_lat2", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("fl_lat3", 32'(bus.out_valid), 32'd1);
        chk("fl_q3",   32'(bus.q3),        32'h70);
        cyc();
        chk("fl_xfer_after", 32'(xfer_cnt), 32'd17);

        // Asynchronous reset with two items in flight and five transfers counted.
        rst_n = 1'b0; model_reset(); cyc(); rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b1); cyc();
        end
        drive(1'b0, 8'h00, 1'b1); cyc(); cyc(); cyc();
        chk("ar_xfer5", 32'(xfer_cnt), 32'd5);
        drive(1'b1, 8'h81, 1'b0); cyc();
        drive(1'b1, 8'h82, 1'b0); cyc();
        drive(1'b0, 8'h00, 1'b0); cyc();
        chk("ar_occ2", 32'(occupancy), 32'd2);
        chk("ar_q3",   32'(bus.q3),    32'h81);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_now_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_now_occ",   32'(occupancy),     32'd0);
        chk("ar_now_xfer",  32'(xfer_cnt),      32'd0);
        chk("ar_now_q3",    32'(bus.q3),        32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h91 + i), 1'b1); cyc();
        end
        drive(1'b0, 8'h00, 1'b1); cyc(); cyc(); cyc();
        chk("ar_resume_xfer", 32'(xfer_cnt), 32'd3);

        // Counter wrap on the 4-bit instance: transfers start at edge 4.
        w_rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            w_bus.in_valid  = 1'b1;
            w_bus.d         = 8'(k);
            w_bus.out_ready = 1'b1;
            cyc();
            if (k == 18) chk("wrap_15", 32'(w_cnt), 32'd15);
            if (k == 19) chk("wrap_0",  32'(w_cnt), 32'd0);
            if (k == 20) chk("wrap_1",  32'(w_cnt), 32'd1);
        end
        w_bus.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe3_flow_ctrl.md
# pipe3_flow_ctrl

Three-stage, WIDTH-bit pipeline register with a per-stage valid/flow controller. The block sequences data through the stages with a ready/valid handshake on both ends. Empty stages are collapsed so bubbles never reach the output. It also supports synchronous flush and keeps occupancy and transfer-count status. The block sits between a producer and consumer that can each stall, and replaces free-running pipeline registers wherever back-pressure exists.

## Interface
- WIDTH, 8, data width of every stage
- CNT_W, 16, width of the output-transfer counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- d  input  WIDTH  input data
- in_valid  input  1  producer offers d this cycle
- in_ready  output  1  block accepts d this cycle (combinational)
- q3  output  WIDTH  stage-3 data
- out_valid  output  1  q3 holds a valid item
- out_ready  input  1  consumer takes q3 this cycle
- flush  input  1  synchronous discard of all in-flight items
- occupancy  output  2  number of valid stages, 0..3
- xfer_cnt  output  CNT_W  count of completed output transfers, wraps

## Operation
- State per stage k (1..3): data register s_k and valid bit v_k. q3 = s3 and out_valid = v3.
- Stage 0 is the input: v0 = in_valid and s0 = d.
- Advance enables, combinational:
  - en3 = !v3 | out_ready
  - en2 = !v2 | en3
  - en1 = !v1 | en2
- in_ready = en1 & !flush.
- On a clock edge with en_k: v_k <= v_{k-1}. s_k <= s_{k-1} only when v_{k-1} = 1; otherwise s_k holds its old value.
- A stage with !en_k holds both its data and valid bit.
- Accept = in_valid & in_ready. Output transfer = v3 & out_ready.
- Flush has priority over everything:
  - At the edge where flush = 1, all v_k <= 0.
  - No input is accepted that cycle.
  - No xfer_cnt increment occurs even if v3 & out_ready.
  - Data registers hold their values.
- occupancy = v1 + v2 + v3, registered and consistent with the valid bits after every edge.
- xfer_cnt increments by 1 on each non-flush output transfer and wraps from 2^CNT_W−1 to 0.
- in_valid while in_ready = 0: the item is not taken. The producer must hold d and in_valid; the block does not check this.

## Timing
- Reset (rst_n low, asynchronous): all v_k = 0, all s_k = 0, q3 = 0, out_valid = 0, occupancy = 0, xfer_cnt = 0.
- While reset is asserted, in_ready = 1 unless flush = 1.
- Reset release: first active edge is the first rising clk with rst_n high.
- Latency with an empty pipe and out_ready = 1: an item accepted at edge E appears in s1 after E, s2 after E+1, s3 after E+2. out_valid is high in the cycle after E+2, i.e. 3 cycles from the acceptance cycle.
- Throughput: 1 item per cycle while out_ready = 1.
- Full (occupancy = 3) with out_ready = 0: in_ready = 0 and all stages hold.
- Full with out_ready = 1: in_ready = 1 in the same cycle. Output and input transfer on the same edge and occupancy stays 3.
- Bubble collapse: with out_ready = 0, a stage advances whenever the stage ahead of it is empty. Fill order with a stalled output: s3, then s2, then s1.
- Reset mid-operation: everything is cleared immediately. In-flight items are lost and xfer_cnt returns to 0.
- Combinational path from out_ready to in_ready is permitted (depth of 3 AND/OR levels).

## Test plan
- Streaming: reset, then d = 0x01..0x0A on consecutive cycles with in_valid = 1 and out_ready = 1.
  -> First out_valid 3 cycles after the first accept, q3 = 0x01..0x0A on consecutive cycles, xfer_cnt = 10, in_ready never low.
- Back-pressure fill: out_ready = 0 and push 0x11, 0x22, 0x33, 0x44.
  -> 0x11 accepted first, then 0x22 and 0x33. in_ready = 0 with 0x44 pending. occupancy = 3, q3 = 0x11.
  -> Then out_ready = 1 for one cycle: 0x11 is transferred and 0x44 is accepted on the same edge. occupancy stays 3.
- Bubble collapse: push 0xA5, idle 2 cycles, push 0x5A, all with out_ready = 0.
  -> 0xA5 in s3, 0x5A in s2, occupancy = 2.
  -> With out_ready = 1, q3 = 0xA5 then 0x5A on consecutive cycles, with no invalid cycle between them.
- Flush: pipe holds 3 items, out_ready = 1, in_valid = 1, flush pulsed for one cycle.
  -> in_ready = 0 that cycle. After the edge out_valid = 0, occupancy = 0, xfer_cnt unchanged.
  -> The next accepted item emerges 3 cycles after its acceptance.
- Reset mid-operation: with 2 items in flight and xfer_cnt = 5, drop rst_n asynchronously between edges.
  -> out_valid, occupancy, xfer_cnt and q3 go to 0 immediately. Normal streaming resumes after release.
- Counter wrap (CNT_W = 4): 17 continuous transfers -> xfer_cnt reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
